// File: rtl/ap_ctrl_stage_sequencer_if.sv
// ap_ctrl_stage_sequencer_if
//   Bundles the top-level ap_ctrl_hs control port, the per-stage sub-kernel
//   handshakes and the cycle-count status outputs of the stage sequencer.
//   master : the sequencer's view (drives ap_done/ap_ready/ap_idle, stage_start,
//            counters and err_protocol; receives ap_start, stage_ready, stage_done)
//   slave  : the surrounding environment's view (the mirror image)
interface ap_ctrl_stage_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
);
    logic                        ap_start;
    logic                        ap_done;
    logic                        ap_ready;
    logic                        ap_idle;
    logic [NUM_STAGES-1:0]       stage_start;
    logic [NUM_STAGES-1:0]       stage_ready;
    logic [NUM_STAGES-1:0]       stage_done;
    logic [NUM_STAGES*CNT_W-1:0] stage_cycles;
    logic [CNT_W-1:0]            total_cycles;
    logic                        err_protocol;

    modport master (
        input  ap_start, stage_ready, stage_done,
        output ap_done, ap_ready, ap_idle, stage_start,
               stage_cycles, total_cycles, err_protocol
    );

    modport slave (
        output ap_start, stage_ready, stage_done,
        input  ap_done, ap_ready, ap_idle, stage_start,
               stage_cycles, total_cycles, err_protocol
    );
endinterface

// File: rtl/ap_ctrl_stage_sequencer.sv
// ap_ctrl_stage_sequencer
//   Answers a top-level ap_ctrl_hs request and issues ap_start to NUM_STAGES
//   sub-kernels strictly in order, measuring per-stage and total latency with
//   saturating counters.
// Ports
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : ap_ctrl_stage_sequencer_if.master
//            ap_start in; ap_done/ap_ready (1-cycle pulse), ap_idle out;
//            stage_start out, stage_ready/stage_done in (one bit per stage);
//            stage_cycles (stage i at [i*CNT_W +: CNT_W]), total_cycles,
//            err_protocol (sticky) out. All outputs are registered.
module ap_ctrl_stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    ap_ctrl_stage_sequencer_if.master     bus
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [NUM_STAGES-1:0] start_reg, start_next;
    logic                  done_reg, done_next;
    logic                  idle_reg, idle_next;
    logic                  err_reg, err_next;
    logic [CNT_W-1:0]      total_reg, total_next;
    logic [CNT_W-1:0]      cyc_reg  [NUM_STAGES];
    logic [CNT_W-1:0]      cyc_next [NUM_STAGES];

    logic [NUM_STAGES-1:0] idx_onehot;
    logic                  cur_done;
    logic                  cur_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Masking with the active stage's one-hot avoids indexing by idx, which
    // keeps non-power-of-two stage counts free of out-of-range selects.
    assign idx_onehot = NUM_STAGES'(1) << idx_reg;
    assign cur_done   = |(bus.stage_done  & idx_onehot);
    assign cur_ready  = |(bus.stage_ready & idx_onehot);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        start_next = start_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        total_next = total_reg;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cyc_next[i] = cyc_reg[i];
        end

        case (state_reg)
            ST_IDLE: begin
                if (|bus.stage_done) begin
                    err_next = 1'b1;
                end
                if (bus.ap_start) begin
                    // The acceptance cycle itself is total cycle 1.
                    state_next = ST_RUN;
                    idx_next   = '0;
                    start_next = NUM_STAGES'(1);
                    total_next = CNT_W'(1);
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        cyc_next[i] = '0;
                    end
                end
            end

            ST_RUN: begin
                if (|(bus.stage_done & ~idx_onehot)) begin
                    err_next = 1'b1;
                end
                for (int i = 0; i < NUM_STAGES; i++) begin
                    if (idx_onehot[i]) begin
                        cyc_next[i] = sat_inc(cyc_reg[i]);
                    end
                end
                total_next = sat_inc(total_reg);
                if (cur_done) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_FIN;
                        start_next = '0;
                        done_next  = 1'b1;
                        // This cycle plus the FIN cycle, so the count is final
                        // while ap_done is visible.
                        total_next = sat_inc(sat_inc(total_reg));
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        start_next = idx_onehot << 1;
                    end
                end else if (cur_ready) begin
                    start_next = '0;
                end
            end

            ST_FIN: begin
                if (|bus.stage_done) begin
                    err_next = 1'b1;
                end
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                start_next = '0;
            end
        endcase

        idle_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            start_reg <= '0;
            done_reg  <= 1'b0;
            idle_reg  <= 1'b1;
            err_reg   <= 1'b0;
            total_reg <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cyc_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            start_reg <= start_next;
            done_reg  <= done_next;
            idle_reg  <= idle_next;
            err_reg   <= err_next;
            total_reg <= total_next;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cyc_reg[i] <= cyc_next[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cyc_out
            assign bus.stage_cycles[gi*CNT_W +: CNT_W] = cyc_reg[gi];
        end
    endgenerate

    assign bus.stage_start  = start_reg;
    assign bus.ap_done      = done_reg;
    assign bus.ap_ready     = done_reg;
    assign bus.ap_idle      = idle_reg;
    assign bus.err_protocol = err_reg;
    assign bus.total_cycles = total_reg;
endmodule
